// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, default sizing and FSM state
// encodings for both the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int TX_STOP_BITS  = 1;
    localparam int TX_FRAME_BITS = 1 + DATA_BITS_DEF + TX_STOP_BITS;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_rx_chk.sv
// Output-protocol checker for the UART receiver flags.
module uart_rx_chk (
    input logic clk,
    input logic rst_n,
    input logic rx_valid,
    input logic rx_frame_err,
    input logic rx_busy
);

    a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(rx_valid && rx_frame_err));

    a_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        rx_valid |=> !rx_valid);

    a_err_single: assert property (@(posedge clk) disable iff (!rst_n)
        rx_frame_err |=> !rx_frame_err);

    a_flag_ends_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (rx_valid || rx_frame_err) |-> !rx_busy);

endmodule

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs, with a selectable
// reset value so idle-high lines do not produce a spurious edge out of reset.
module uart_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // metastability chain, clocked every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start detection, mid-bit sampling,
// registered one-cycle valid / frame-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick_16x,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    logic [DATA_BITS:0]   shift_in_s;

    rx_state_t            state_r;
    rx_state_t            state_next_s;
    logic [TW-1:0]        tick_r;
    logic [TW-1:0]        tick_next_s;
    logic [BW-1:0]        bit_r;
    logic [BW-1:0]        bit_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_next_s;
    logic                 valid_r;
    logic                 valid_next_s;
    logic                 err_r;
    logic                 err_next_s;
    logic                 busy_r;
    logic                 busy_next_s;

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_line),
        .q     (rx_s)
    );

    // LSB-first reception: each new sample enters at the top and shifts down
    assign shift_in_s = {rx_s, shift_r};

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            tick_r  <= tick_next_s;
            bit_r   <= bit_next_s;
            shift_r <= shift_next_s;
            data_r  <= data_next_s;
            valid_r <= valid_next_s;
            err_r   <= err_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // next-state logic; everything except the flag pulses holds between ticks
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        bit_next_s   = bit_r;
        shift_next_s = shift_r;
        data_next_s  = data_r;
        valid_next_s = 1'b0;
        err_next_s   = 1'b0;
        busy_next_s  = busy_r;

        if (baud_tick_16x) begin
            case (state_r)
                RX_IDLE: begin
                    if (rx_s == START_BIT) begin
                        state_next_s = RX_START;
                        tick_next_s  = TICK_ZERO;
                        busy_next_s  = 1'b1;
                    end else begin
                        state_next_s = RX_IDLE;
                    end
                end
                RX_START: begin
                    if (tick_r == TICK_MID) begin
                        tick_next_s = TICK_ZERO;
                        if (rx_s == START_BIT) begin
                            state_next_s = RX_DATA;
                            bit_next_s   = BIT_ZERO;
                        end else begin
                            // glitch shorter than half a bit: drop silently
                            state_next_s = RX_IDLE;
                            busy_next_s  = 1'b0;
                        end
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                RX_DATA: begin
                    if (tick_r == TICK_LAST) begin
                        tick_next_s  = TICK_ZERO;
                        shift_next_s = shift_in_s[DATA_BITS:1];
                        bit_next_s   = bit_r + BIT_ONE;
                        if (bit_r == BIT_LAST) begin
                            state_next_s = RX_STOP;
                        end else begin
                            state_next_s = RX_DATA;
                        end
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                RX_STOP: begin
                    if (tick_r == TICK_LAST) begin
                        // back to IDLE mid stop bit so a following start is not missed
                        tick_next_s  = TICK_ZERO;
                        state_next_s = RX_IDLE;
                        busy_next_s  = 1'b0;
                        if (rx_s == STOP_BIT) begin
                            data_next_s  = shift_r;
                            valid_next_s = 1'b1;
                        end else begin
                            err_next_s = 1'b1;
                        end
                    end else begin
                        tick_next_s = tick_r + TICK_ONE;
                    end
                end
                default: begin
                    state_next_s = RX_IDLE;
                    tick_next_s  = TICK_ZERO;
                    bit_next_s   = BIT_ZERO;
                    busy_next_s  = 1'b0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign rx_data      = data_r;
    assign rx_valid     = valid_r;
    assign rx_frame_err = err_r;
    assign rx_busy      = busy_r;

    uart_rx_chk u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_valid     (valid_r),
        .rx_frame_err (err_r),
        .rx_busy      (busy_r)
    );

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the downstream consumer of the serial line driven by the team's UART transmitter.
- Oversamples rx_line with a shared 16x baud tick and recovers 8N1 frames (start 0, 8 data bits LSB-first, 1 stop bit).
- Presents each received byte with a one-cycle valid pulse and flags bad stop bits.
- Sits between the pad/loopback and the host-side RX FIFO or register interface.

Parameters:
- OVERSAMPLE, 16, baud_tick_16x ticks per bit period; must be even and at least 8.
- DATA_BITS, 8, data bits per frame; rx_data width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- baud_tick_16x  input  1  single-clk pulse, OVERSAMPLE times per bit period
- rx_line  input  1  asynchronous serial input, idle high
- rx_data  output  DATA_BITS  last correctly framed byte
- rx_valid  output  1  one-clk pulse: rx_data updated
- rx_frame_err  output  1  one-clk pulse: stop bit sampled 0
- rx_busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (asynchronous): rx_data=0, rx_valid=0, rx_frame_err=0, rx_busy=0, state=IDLE, counters=0, both synchronizer flops=1.
- Synchronizer:
  - rx_line passes through a 2-flop synchronizer clocked every clk, independent of the tick; rx_s is the second-flop output.
  - All FSM decisions use rx_s only.
- Counters:
  - tick_cnt (log2 OVERSAMPLE bits) and bit_cnt (log2 DATA_BITS+1 bits) change only on clk edges where baud_tick_16x=1.
  - No state transitions occur on non-tick cycles, except that rx_valid and rx_frame_err self-clear.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with rx_s=0, go to START with tick_cnt=0 and rx_busy=1.
  - START: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA with tick_cnt=0, bit_cnt=0.
    - rx_s=1: false start. Go to IDLE with rx_busy=0 and no output pulse.
  - DATA: on each tick, tick_cnt++. On the tick where tick_cnt==OVERSAMPLE-1:
    - shift register shifts right, rx_s enters the MSB (LSB-first reception).
    - tick_cnt=0, bit_cnt++.
    - After the DATA_BITS-th sample, go to STOP.
  - STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s.
    - rx_s=1: rx_data<=shift register; rx_valid=1 for exactly one clk.
    - rx_s=0: rx_frame_err=1 for exactly one clk; rx_data is held at its previous value.
    - In both cases go to IDLE with rx_busy=0.
- Output timing:
  - rx_valid and rx_frame_err are registered; they are high in the clk cycle after the stop-sample tick edge, then cleared.
  - They are never high together.
- Sampling point: all data and stop samples are taken mid-bit, OVERSAMPLE/2 ticks after the detected falling edge, plus k*OVERSAMPLE ticks for bit k.
- Back-to-back frames:
  - IDLE is re-entered mid stop bit, so a start bit immediately following the stop bit is detected with no lost frame.
  - A line held low after a frame error (break) re-enters START on the next tick and produces frame errors repeatedly. This behaviour is accepted; no break detector.
- Edge detection: level-based on rx_s in IDLE. Line noise shorter than OVERSAMPLE/2 ticks is rejected by the START check.
- Reset mid-frame: immediate return to the reset values above. The partial byte is discarded, with no pulse on either flag.
- baud_tick_16x held low: the FSM freezes in its current state and outputs hold; no timeout.

Decomposition:
- Shared package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP)
  - OVERSAMPLE and DATA_BITS defaults
  - frame constants: START_BIT=0, STOP_BIT=1
  - The transmitter's frame constants are placed in the same package.
- Sub-module uart_sync2: generic 2-flop synchronizer with reset value parameter (here 1). It is reused later for CTS/RTS inputs.

Test Plan:
1. Loopback from the UART transmitter, baud_tick_16x = 16x its 1x tick, tx_data=0xA5 -> one rx_valid pulse, rx_data=0xA5, rx_frame_err never high, rx_busy high about 9.5 bit periods.
2. Back-to-back 0x00 then 0xFF then 0x55, each tx_start issued as soon as tx_busy drops -> three rx_valid pulses with rx_data 0x00, 0xFF, 0x55 in order; no frame errors.
3. Bit-banged frame with data 0x3C and stop bit 0 -> rx_frame_err single pulse, no rx_valid, rx_data keeps previous value (0x55); next good frame 0x81 -> rx_valid, rx_data=0x81.
4. rx_line low for 5 ticks then high (glitch) -> returns to IDLE at tick 8, rx_busy pulses high then 0, no rx_valid and no rx_frame_err.
5. rst_n asserted during data bit 4 of 0x96, released, then 0x69 sent -> all outputs 0 during reset, then a single rx_valid with rx_data=0x69.
6. Timing skew: bit period of 16 ticks ±1 tick, i.e. 15 and 17 ticks/bit, data 0xC3 -> rx_data=0xC3 in both cases.
